aes_key_expander: RTL and testbench

//   Iterative AES-128 key schedule. Expands one 128-bit cipher key into the
//   (NR+1)x128-bit round-key bus 'word' consumed by INV_cipher (and cipher).

---
 rtl/aes_key_expander_if.sv | 14 +
 rtl/aes_key_expander.sv | 87 ++++++++
 tb/tb_aes_key_expander.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: start/key request and round-key schedule result bundle
interface aes_key_expander_if #(
  parameter int NR = 10
);
  localparam int WORD_W = 128 * (NR + 1);
  logic              start;
  logic [127:0]      key;
  logic [WORD_W-1:0] word;
  logic              busy;
  logic              done;
  logic              valid;
  modport master (output start, key, input word, busy, done, valid);
  modport slave  (input start, key, output word, busy, done, valid);
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule, one round key per clock
module aes_key_expander #(
  parameter int NR = 10
) (
  input logic              clk,
  input logic              rst_n,
  aes_key_expander_if.slave kx
);
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [3:0] LAST = 4'(NR);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  state_t            state_q, state_d;
  logic [3:0]        round_q, round_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [0:NR][127:0] slots_q, slots_d;
  logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  // One key-schedule step: derive round key r from round key r-1.
  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  // Next-state: capture key on start while idle, then fill one slot per cycle.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    slots_d = slots_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    if (state_q == IDLE && kx.start) begin
      slots_d    = '0;
      slots_d[0] = kx.key;
      valid_d    = 1'b0;
      busy_d     = 1'b1;
      round_d    = 4'd1;
      rcon_d     = 8'h01;
      state_d    = EXPAND;
    end else if (state_q == EXPAND) begin
      slots_d[round_q] = next_rk(slots_q[round_q - 4'd1], rcon_q);
      rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      round_d = round_q + 4'd1;
      busy_d  = round_q != LAST;
      done_d  = round_q == LAST;
      valid_d = round_q == LAST;
      state_d = round_q == LAST ? IDLE : EXPAND;
    end
  end
  // State register with synchronous active-low reset that aborts any expansion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      slots_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      slots_q <= slots_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end
  assign kx.word  = slots_q;
  assign kx.busy  = busy_q;
  assign kx.done  = done_q;
  assign kx.valid = valid_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: random and FIPS-197 key schedules against a reference model
module tb_aes_key_expander;
  localparam int NR = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_err = 0;
  logic [7:0] sb [256];
  logic [127:0] exp_rk [0:NR];
  aes_key_expander_if #(.NR(NR)) kx ();
  aes_key_expander #(.NR(NR)) dut (.clk(clk), .rst_n(rst_n), .kx(kx));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  function automatic logic [127:0] slot(input int r);
    return kx.word[128*(NR+1)-1-128*r -: 128];
  endfunction
  task automatic check_schedule(input string tag, input logic [127:0] key);
    model(key);
    for (int r = 0; r <= NR; r++) check($sformatf("%s_rk%0d", tag, r), slot(r), exp_rk[r]);
  endtask
  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    kx.start = 1'b1;
    kx.key = k;
    @(negedge clk);
    kx.start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 1;
    while (!kx.done && n < 40) begin
      @(negedge clk);
      if (!kx.done) n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(NR));
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [127:0] k, k2;
    int pulses, at;
    kx.start = 1'b0;
    kx.key = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_word", 128'(|kx.word), 128'd0);
    check("rst_flags", {kx.busy, kx.done, kx.valid}, 128'd0);
    rst_n = 1'b1;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    do_start(k);
    check("fips_busy", {kx.busy, kx.done, kx.valid}, 128'b100);
    wait_done("fips");
    check("fips_r1", slot(1), 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", slot(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_valid", {kx.busy, kx.valid}, 128'b01);
    check_schedule("fips", k);
    @(negedge clk);
    check("fips_done_pulse", 128'(kx.done), 128'd0);
    do_start('0);
    wait_done("zero");
    check("zero_r1", slot(1), 128'h62636363626363636263636362636363);
    check("zero_r10", slot(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    repeat (5) @(negedge clk);
    kx.key = rnd128();
    @(negedge clk);
    check("zero_hold_valid", 128'(kx.valid), 128'd1);
    check_schedule("zero_hold", '0);
    k2 = rnd128();
    do_start(k);
    pulses = 0;
    at = 0;
    for (int c = 1; c <= 14; c++) begin
      kx.start = (c == 3 || c == 7);
      kx.key = (c == 3 || c == 7) ? k2 : k;
      @(negedge clk);
      if (kx.done) begin
        pulses++;
        at = c;
      end
    end
    kx.start = 1'b0;
    check("restart_pulses", 128'(pulses), 128'd1);
    check("restart_done_at", 128'(at), 128'(NR));
    check_schedule("restart", k);
    do_start(rnd128());
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_word", 128'(|kx.word), 128'd0);
    check("abort_flags", {kx.busy, kx.done, kx.valid}, 128'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (kx.done || kx.valid || kx.busy) pulses++;
    end
    check("abort_quiet", 128'(pulses), 128'd0);
    k = rnd128();
    do_start(k);
    wait_done("after_abort");
    check_schedule("after_abort", k);
    for (int i = 0; i < 4; i++) begin
      k = rnd128();
      kx.start = 1'b1;
      kx.key = k;
      @(negedge clk);
      kx.start = 1'b0;
      kx.key = rnd128();
      check($sformatf("b2b%0d_start", i), {kx.busy, kx.done, kx.valid}, 128'b100);
      wait_done($sformatf("b2b%0d", i));
      check_schedule($sformatf("b2b%0d", i), k);
    end
    @(negedge clk);
    check("final_done_pulse", 128'(kx.done), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
